rf_writeback: RTL and testbench
===============================

Name: rf_writeback

Overview:
- Architectural integer register file: one synchronous write port fed by the WB stage, two combinational read ports feeding the ID-stage operand muxes.
- Write-through bypass so ID sees the value WB commits in the same cycle.
- Per-register busy scoreboard for long-latency producers (loads, multi-cycle ops); generates the ID stall.
- Sits between WB (writer) and ID operand selection (reader).

Parameters:
- XLEN, 32, data width of each register
- NUM_REGS, 32, register count; address width = $clog2(NUM_REGS)
- BYPASS_EN, 1, 1 = same-cycle WB-to-read bypass enabled; 0 = read returns the stored array value only

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_addr  in  5  ID source 1 index
- rs2_addr  in  5  ID source 2 index
- rs1_used  in  1  ID instruction reads rs1 (SRC_RS1 selected)
- rs2_used  in  1  ID instruction reads rs2 (SRC_RS2 selected)
- rs1_data  out  XLEN  source 1 value
- rs2_data  out  XLEN  source 2 value
- issue_valid  in  1  ID instruction leaves ID this cycle if not stalled
- issue_rd  in  5  its destination index
- issue_long  in  1  destination produced by a long-latency unit; mark busy
- wb_valid  in  1  WB commits a result
- wb_rd  in  5  WB destination index
- wb_data  in  XLEN  WB result
- kill_valid  in  1  a squashed long-latency instruction will never write back
- kill_rd  in  5  its destination index
- stall  out  1  hold ID/IF this cycle
- busy_vec  out  NUM_REGS  scoreboard state, debug/trace

Behaviour:
Reset:
- rst asserts: all registers = 0, busy_vec = 0, immediately (asynchronous).
- Outputs are combinational on the array and inputs, so they reflect 0 contents during reset.
- Reset mid-operation drops all pending busy bits; no writeback is lost, because the pipeline is also reset.

Write port:
- At posedge clk, if wb_valid and wb_rd != 0: reg[wb_rd] <= wb_data.
- Writes to x0 are discarded; reg[0] reads 0 always.

Read ports:
- Combinational, zero latency.
- rsN_data = 0 if rsN_addr == 0.
- Otherwise, if BYPASS_EN and wb_valid and wb_rd == rsN_addr: rsN_data = wb_data.
- Otherwise rsN_data = reg[rsN_addr].

Scoreboard:
- raw1 = rs1_used & busy[rs1_addr] & !(wb_valid & wb_rd == rs1_addr); raw2 likewise for rs2.
- waw = issue_valid & issue_long & busy[issue_rd] & !(wb_valid & wb_rd == issue_rd).
- stall = raw1 | raw2 | waw; combinational.
- Set: at posedge, busy[issue_rd] <= 1 when issue_valid & issue_long & !stall & issue_rd != 0.
- Clear: at posedge, busy[wb_rd] <= 0 when wb_valid; busy[kill_rd] <= 0 when kill_valid.
- Same-cycle set and clear on the same index: set wins, because the new producer is younger.
- busy[0] is constant 0.
- With BYPASS_EN=0, the wb-match terms are dropped from raw1/raw2/waw, so the stall lasts one extra cycle.

Arithmetic/width:
- No arithmetic.
- Index width is fixed at 5 in ports; NUM_REGS < 32 makes out-of-range indices read 0 and ignores writes to them.

Decomposition:
- cpu_types_pkg gains: reg_idx_t (logic [4:0]), xlen_t (logic [XLEN-1:0]), and REG_ZERO = 5'd0.
- One sub-module, rf_scoreboard: busy_vec register, set/clear/kill logic, stall generation.
- rf_writeback instantiates it alongside the storage array and the bypass muxes.

Test Plan:
- Reset then read: rst pulse, rs1_addr=5, rs2_addr=0 -> rs1_data=0, rs2_data=0, busy_vec=0, stall=0.
- Write then read: wb_valid=1, wb_rd=7, wb_data=0xDEADBEEF for one cycle; next cycle rs1_addr=7 -> rs1_data=0xDEADBEEF. x0 write of 0x1234 -> reading x0 gives 0.
- Same-cycle bypass: reg[3]=0x11; wb_rd=3, wb_data=0x22 with rs2_addr=3 in the same cycle -> rs2_data=0x22 that cycle. With BYPASS_EN=0 -> 0x11 that cycle, 0x22 the next.
- Load-use stall: issue_valid=1, issue_long=1, issue_rd=9 -> busy[9]=1. Next cycle rs1_addr=9, rs1_used=1 -> stall=1. Hold 3 cycles, then wb_rd=9, wb_data=0x55 -> stall=0 that cycle (bypass), rs1_data=0x55, busy[9]=0 next cycle.
- Kill and WAW: busy[4]=1. Issue of a long op with rd=4 -> stall=1 and busy unchanged. Then kill_valid=1, kill_rd=4 -> busy[4]=0, stall=0 that cycle, busy[4] set again next cycle.
- Set/clear collision: busy[6]=1; in one cycle wb_rd=6 and issue long rd=6 (stall=0 via wb match) -> busy[6]=1 after the edge. rs_used=0 with a busy rs -> no stall.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared register-index and data-word types for the integer pipeline.
package cpu_types_pkg;
  localparam int XLEN = 32;
  typedef logic [4:0] reg_idx_t;
  typedef logic [XLEN-1:0] xlen_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits for long-latency producers and the ID stall they cause.
module rf_scoreboard import cpu_types_pkg::*; #(
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  reg_idx_t            rs1_addr,
  input  reg_idx_t            rs2_addr,
  input  logic                rs1_used,
  input  logic                rs2_used,
  input  logic                issue_valid,
  input  reg_idx_t            issue_rd,
  input  logic                issue_long,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  input  logic                kill_valid,
  input  reg_idx_t            kill_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [31:0] busy_all, busy_nxt;
  logic raw1, raw2, waw, set_en;
  // Widening to the full index space makes out-of-range indices read as not busy.
  always_comb begin
    busy_all = 32'(busy_q);
    raw1 = rs1_used & busy_all[rs1_addr] & ~(BYPASS_EN & wb_valid & (wb_rd == rs1_addr));
    raw2 = rs2_used & busy_all[rs2_addr] & ~(BYPASS_EN & wb_valid & (wb_rd == rs2_addr));
    waw = issue_valid & issue_long & busy_all[issue_rd] & ~(BYPASS_EN & wb_valid & (wb_rd == issue_rd));
    stall = raw1 | raw2 | waw;
    set_en = issue_valid & issue_long & ~stall & (issue_rd != REG_ZERO);
    busy_nxt = busy_all;
    if (wb_valid) busy_nxt[wb_rd] = 1'b0;
    if (kill_valid) busy_nxt[kill_rd] = 1'b0;
    if (set_en) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    busy_d = busy_nxt[NUM_REGS-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else busy_q <= busy_d;
  end
  assign busy_vec = busy_q;
endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: integer register file with one WB write port, two bypassed read ports
// and the busy scoreboard that stalls ID on RAW/WAW hazards.
module rf_writeback import cpu_types_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  reg_idx_t            rs1_addr,
  input  reg_idx_t            rs2_addr,
  input  logic                rs1_used,
  input  logic                rs2_used,
  output logic [XLEN-1:0]     rs1_data,
  output logic [XLEN-1:0]     rs2_data,
  input  logic                issue_valid,
  input  reg_idx_t            issue_rd,
  input  logic                issue_long,
  input  logic                wb_valid,
  input  reg_idx_t            wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                kill_valid,
  input  reg_idx_t            kill_rd,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam int AW = $clog2(NUM_REGS);
  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [XLEN-1:0] regs_d [NUM_REGS];
  logic wb_ok, hit1, hit2;
  function automatic logic in_range(reg_idx_t a);
    return 32'(a) < NUM_REGS;
  endfunction
  // x0 and indices beyond NUM_REGS read as zero and swallow writes.
  always_comb begin
    wb_ok = wb_valid && wb_rd != REG_ZERO && in_range(wb_rd);
    regs_d = regs_q;
    if (wb_ok) regs_d[AW'(wb_rd)] = wb_data;
    hit1 = BYPASS_EN && wb_valid && wb_rd == rs1_addr;
    hit2 = BYPASS_EN && wb_valid && wb_rd == rs2_addr;
    rs1_data = (rs1_addr == REG_ZERO || !in_range(rs1_addr)) ? '0 : hit1 ? wb_data : regs_q[AW'(rs1_addr)];
    rs2_data = (rs2_addr == REG_ZERO || !in_range(rs2_addr)) ? '0 : hit2 ? wb_data : regs_q[AW'(rs2_addr)];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  rf_scoreboard #(.NUM_REGS(NUM_REGS), .BYPASS_EN(BYPASS_EN)) u_sb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_long(issue_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .kill_valid(kill_valid), .kill_rd(kill_rd),
    .stall(stall), .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed plus randomized checks of rf_writeback, with and without bypass,
// against an array-based reference model.
module tb_rf_writeback;
  import cpu_types_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  reg_idx_t rs1_addr, rs2_addr, issue_rd, wb_rd, kill_rd;
  logic rs1_used, rs2_used, issue_valid, issue_long, wb_valid, kill_valid;
  logic [31:0] wb_data;
  logic [31:0] rs1_d1, rs2_d1, rs1_d0, rs2_d0, busy1, busy0;
  logic stall1, stall0;
  rf_writeback #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .rs1_data(rs1_d1), .rs2_data(rs2_d1), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_long(issue_long), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .kill_valid(kill_valid), .kill_rd(kill_rd), .stall(stall1), .busy_vec(busy1)
  );
  rf_writeback #(.XLEN(32), .NUM_REGS(32), .BYPASS_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .rs1_data(rs1_d0), .rs2_data(rs2_d0), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_long(issue_long), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .kill_valid(kill_valid), .kill_rd(kill_rd), .stall(stall0), .busy_vec(busy0)
  );
  logic [31:0] mem [32];
  logic [31:0] bsy [2];
  int n_checks = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic fresh(int c, reg_idx_t a);
    return c == 1 && wb_valid && wb_rd == a;
  endfunction
  function automatic logic [31:0] m_read(int c, reg_idx_t a);
    if (a == 0) return 32'h0;
    if (fresh(c, a)) return wb_data;
    return mem[a];
  endfunction
  function automatic logic m_stall(int c);
    logic [31:0] b;
    b = bsy[c];
    return (rs1_used && b[rs1_addr] && !fresh(c, rs1_addr)) ||
           (rs2_used && b[rs2_addr] && !fresh(c, rs2_addr)) ||
           (issue_valid && issue_long && b[issue_rd] && !fresh(c, issue_rd));
  endfunction
  task automatic idle();
    {rs1_addr, rs2_addr, issue_rd, wb_rd, kill_rd} = '0;
    {rs1_used, rs2_used, issue_valid, issue_long, wb_valid, kill_valid} = '0;
    wb_data = '0;
  endtask
  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bsy[0] = '0;
    bsy[1] = '0;
  endtask
  // Compare both instances against the model, then advance the model across the clock edge.
  task automatic cycle();
    logic [31:0] nb [2];
    logic st;
    #1;
    for (int c = 0; c < 2; c++) begin
      st = m_stall(c);
      check(c ? "rs1_byp" : "rs1_nobyp", c ? rs1_d1 : rs1_d0, m_read(c, rs1_addr));
      check(c ? "rs2_byp" : "rs2_nobyp", c ? rs2_d1 : rs2_d0, m_read(c, rs2_addr));
      check(c ? "stall_byp" : "stall_nobyp", c ? stall1 : stall0, st);
      check(c ? "busy_byp" : "busy_nobyp", c ? busy1 : busy0, bsy[c]);
      nb[c] = bsy[c];
      if (wb_valid) nb[c][wb_rd] = 1'b0;
      if (kill_valid) nb[c][kill_rd] = 1'b0;
      if (issue_valid && issue_long && !st && issue_rd != 0) nb[c][issue_rd] = 1'b1;
    end
    @(posedge clk);
    if (wb_valid && wb_rd != 0) mem[wb_rd] = wb_data;
    bsy[0] = nb[0];
    bsy[1] = nb[1];
    @(negedge clk);
  endtask
  function automatic reg_idx_t r_idx();
    return ($urandom_range(0, 3) == 0) ? reg_idx_t'($urandom_range(0, 31)) : reg_idx_t'($urandom_range(0, 7));
  endfunction
  initial begin
    idle();
    model_reset();
    rs1_addr = 5'd5;
    #1 rst = 1'b1;
    #1;
    check("reset_rs1", rs1_d1, 32'h0);
    check("reset_rs2", rs2_d1, 32'h0);
    check("reset_busy", busy1, 32'h0);
    check("reset_stall", stall1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    // write then read, x0 write discarded
    idle(); wb_valid = 1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF; cycle();
    idle(); rs1_addr = 5'd7; #1 check("wr_rd_x7", rs1_d1, 32'hDEADBEEF); cycle();
    idle(); wb_valid = 1; wb_rd = 5'd0; wb_data = 32'h1234; cycle();
    idle(); rs1_addr = 5'd0; #1 check("x0_zero", rs1_d1, 32'h0); cycle();
    // same-cycle bypass
    idle(); wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h11; cycle();
    idle(); wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h22; rs2_addr = 5'd3;
    #1 check("byp_same", rs2_d1, 32'h22);
    check("nobyp_same", rs2_d0, 32'h11);
    cycle();
    idle(); rs2_addr = 5'd3; #1 check("nobyp_next", rs2_d0, 32'h22); cycle();
    // load-use stall
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 5'd9; cycle();
    idle(); rs1_addr = 5'd9; rs1_used = 1;
    #1 check("lu_stall", stall1, 1'b1);
    check("lu_busy9", busy1[9], 1'b1);
    repeat (3) cycle();
    wb_valid = 1; wb_rd = 5'd9; wb_data = 32'h55;
    #1 check("lu_release_byp", stall1, 1'b0);
    check("lu_release_nobyp", stall0, 1'b1);
    check("lu_data", rs1_d1, 32'h55);
    cycle();
    idle(); rs1_addr = 5'd9; rs1_used = 1;
    #1 check("lu_busy9_clr", busy1[9], 1'b0);
    check("lu_nobyp_go", stall0, 1'b0);
    cycle();
    // WAW stall then kill
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 5'd4; cycle();
    #1 check("waw_stall", stall1, 1'b1);
    cycle();
    idle(); kill_valid = 1; kill_rd = 5'd4;
    #1 check("waw_busy_held", busy1[4], 1'b1);
    check("kill_nostall", stall1, 1'b0);
    cycle();
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 5'd4;
    #1 check("kill_cleared", busy1[4], 1'b0);
    check("reissue_ok", stall1, 1'b0);
    cycle();
    idle(); #1 check("reissue_busy", busy1[4], 1'b1); cycle();
    idle(); kill_valid = 1; kill_rd = 5'd4; cycle();
    // set/clear collision: younger producer wins
    idle(); issue_valid = 1; issue_long = 1; issue_rd = 5'd6; cycle();
    wb_valid = 1; wb_rd = 5'd6; wb_data = 32'h66;
    #1 check("coll_nostall", stall1, 1'b0);
    cycle();
    idle(); rs1_addr = 5'd6; rs1_used = 0;
    #1 check("coll_busy6", busy1[6], 1'b1);
    check("unused_nostall", stall1, 1'b0);
    cycle();
    idle(); wb_valid = 1; wb_rd = 5'd6; wb_data = 32'h67; cycle();
    // randomized traffic with one mid-run asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        idle(); rs1_addr = 5'd5; rs2_addr = 5'd9;
        rst = 1'b1;
        #1;
        check("midrst_rs1", rs1_d1, 32'h0);
        check("midrst_rs2", rs2_d0, 32'h0);
        check("midrst_busy", busy1, 32'h0);
        check("midrst_stall", stall1, 1'b0);
        rst = 1'b0;
        model_reset();
      end
      rs1_addr = r_idx(); rs2_addr = r_idx(); issue_rd = r_idx(); wb_rd = r_idx(); kill_rd = r_idx();
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      issue_valid = 1'($urandom_range(0, 1));
      issue_long = ($urandom_range(0, 2) == 0);
      wb_valid = 1'($urandom_range(0, 1));
      kill_valid = ($urandom_range(0, 7) == 0);
      wb_data = $urandom;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
